// File: rtl/cache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped L1 cache.
package cache_pkg;
  localparam int unsigned CACHE_IDX_W    = 3;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LINE_W         = 128;
  localparam int unsigned ADDR_W         = 30;
  localparam int unsigned OFF_W          = 2;
  localparam int unsigned MADDR_W        = 28;
  localparam int unsigned CACHE_TAG_W    = ADDR_W - CACHE_IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WBACK = 2'd1,
    ALLOC = 2'd2
  } state_t;
endpackage

// File: rtl/cache_line_array.sv
// Valid/dirty/tag/data storage: combinational read, one word-write port, one line-fill port.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int unsigned IDX_W = CACHE_IDX_W,
  parameter int unsigned TAG_W = CACHE_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line
);
  localparam int unsigned LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_line;
    end else if (wr_en) begin
      data_q[idx][wr_off*WORD_W +: WORD_W] <= wr_word;
    end
  end
endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back/write-allocate L1 cache with stall-on-miss and held memory handshake.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module l1_cache
  import cache_pkg::*;
#(
  parameter int unsigned IDX_W = CACHE_IDX_W,
  parameter int unsigned WORDS = WORDS_PER_LINE
) (
  input  logic                      clk,
  input  logic                      proc_reset,
  input  logic                      proc_read,
  input  logic                      proc_write,
  input  logic [ADDR_W-1:0]         proc_addr,
  input  logic [WORD_W-1:0]         proc_wdata,
  output logic [WORD_W-1:0]         proc_rdata,
  output logic                      proc_stall,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [MADDR_W-1:0]        mem_addr,
  output logic [WORDS*WORD_W-1:0]   mem_wdata,
  input  logic [WORDS*WORD_W-1:0]   mem_rdata,
  input  logic                      mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]               hit_cnt,
  output logic [31:0]               miss_cnt
`endif
);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;

  state_t state_q, state_d;

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic              req, hit;
  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              wr_en, fill_en;

  assign off     = proc_addr[OFF_W-1:0];
  assign idx     = proc_addr[IDX_W+OFF_W-1:OFF_W];
  assign req_tag = proc_addr[ADDR_W-1:IDX_W+OFF_W];
  assign req     = proc_read | proc_write;
  assign hit     = rd_valid && (rd_tag == req_tag);

  cache_line_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (proc_reset),
    .idx       (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (wr_en),
    .wr_off    (off),
    .wr_word   (proc_wdata),
    .fill_en   (fill_en),
    .fill_tag  (req_tag),
    .fill_line (mem_rdata)
  );

  assign proc_rdata = (state_q == IDLE && hit) ? rd_line[off*WORD_W +: WORD_W] : '0;

  always_ff @(posedge clk) begin
    if (proc_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    wr_en      = 1'b0;
    fill_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            wr_en = proc_write;
          end else begin
            proc_stall = 1'b1;
            state_d    = (rd_valid && rd_dirty) ? WBACK : ALLOC;
          end
        end
      end
      WBACK: begin
        proc_stall = 1'b1;
        if (mem_ready) state_d = ALLOC;
      end
      ALLOC: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory request registers follow the state transitions so strobes, address and victim stay held.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (state_d == WBACK) begin
            mem_write <= 1'b1;
            mem_addr  <= {rd_tag, idx};
            mem_wdata <= rd_line;
          end else if (state_d == ALLOC) begin
            mem_read <= 1'b1;
            mem_addr <= {req_tag, idx};
          end
        end
        WBACK: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= {req_tag, idx};
          end
        end
        ALLOC: begin
          if (mem_ready) mem_read <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == IDLE && req) begin
      if (hit && hit_cnt != '1)   hit_cnt  <= hit_cnt + 32'd1;
      if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule
